// File: rtl/sdc_wb_timeout.sv
`default_nettype none
// sdc_wb_timeout: zero-latency classic-Wishbone watchdog. A strobed request left
// unanswered for TIMEOUT cycles is aborted and terminated upstream with an error.
module sdc_wb_timeout #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            s_cyc,
  input  logic            s_stb,
  input  logic            s_we,
  input  logic [AW-1:0]   s_adr,
  input  logic [DW-1:0]   s_dat_i,
  input  logic [DW/8-1:0] s_sel,
  output logic            s_ack,
  output logic            s_err,
  output logic [DW-1:0]   s_dat_o,
  output logic            m_cyc,
  output logic            m_stb,
  output logic            m_we,
  output logic [AW-1:0]   m_adr,
  output logic [DW-1:0]   m_dat_o,
  output logic [DW/8-1:0] m_sel,
  input  logic            m_ack,
  input  logic            m_err,
  input  logic [DW-1:0]   m_dat_i,
  output logic            to_pulse,
  output logic [15:0]     to_count,
  output logic [AW-1:0]   to_adr,
  output logic            to_we
);

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_ABORT = 1'b1
  } state_e;

  localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [15:0]     to_count_q, to_count_d;
  logic [AW-1:0]   to_adr_q, to_adr_d;
  logic            to_we_q, to_we_d;
  logic            to_pulse_q, to_pulse_d;

  logic            w_req;
  logic            w_abort;
  logic            w_hit;

  assign w_req   = s_cyc & s_stb;
  assign w_abort = (state_q == ST_ABORT);
  // A termination on the last allowed cycle beats the timeout.
  assign w_hit   = ~w_abort & w_req & ~m_ack & ~m_err & (wcnt_q == WCNT_LAST);

  always_comb begin
    state_d    = ST_PASS;
    wcnt_d     = wcnt_q + 16'd1;
    to_count_d = to_count_q;
    to_adr_d   = to_adr_q;
    to_we_d    = to_we_q;
    to_pulse_d = w_hit;
    if (~w_req | m_ack | m_err | w_abort) begin
      wcnt_d = 16'd0;
    end
    if (w_hit) begin
      state_d  = ST_ABORT;
      to_adr_d = s_adr;
      to_we_d  = s_we;
      if (to_count_q != 16'hFFFF) begin
        to_count_d = to_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_PASS;
      wcnt_q     <= 16'd0;
      to_count_q <= 16'd0;
      to_adr_q   <= '0;
      to_we_q    <= 1'b0;
      to_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      to_count_q <= to_count_d;
      to_adr_q   <= to_adr_d;
      to_we_q    <= to_we_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  assign m_cyc    = s_cyc & ~w_abort;
  assign m_stb    = s_stb & ~w_abort;
  assign m_we     = s_we;
  assign m_adr    = s_adr;
  assign m_dat_o  = s_dat_i;
  assign m_sel    = s_sel;
  assign s_dat_o  = m_dat_i;
  assign s_err    = w_abort | (m_err & m_cyc);
  assign s_ack    = ~w_abort & m_ack & m_cyc & ~m_err;

  assign to_pulse = to_pulse_q;
  assign to_count = to_count_q;
  assign to_adr   = to_adr_q;
  assign to_we    = to_we_q;

endmodule
`default_nettype wire
